// File: rtl/inst_decode_if.sv
// Fetch-to-decode handshake and decoded-instruction bus for inst_decode.
interface inst_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_4;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_4;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [2:0]  alu_op;
    logic        illegal;
    logic        raw_hazard;
    logic [15:0] dec_count;

    // Decoder side
    modport slave (
        input  in_valid, in_pc_4, in_inst, out_ready,
        output in_ready, out_valid, out_pc_4, opcode, funct, rs, rt, rd, shamt,
               alu_op, illegal, raw_hazard, dec_count
    );

    // Fetch/downstream side
    modport master (
        output in_valid, in_pc_4, in_inst, out_ready,
        input  in_ready, out_valid, out_pc_4, opcode, funct, rs, rt, rd, shamt,
               alu_op, illegal, raw_hazard, dec_count
    );
endinterface

// File: rtl/inst_decode.sv
// Instruction decoder: 2-entry {pc_4, inst} FIFO with combinational R-type
// decode of the head entry, RAW hazard flag against the last legal pop, and
// a wrapping pop counter.
module inst_decode (
    input logic          clk,
    input logic          rst_n,
    inst_decode_if.slave bus
);

    logic [63:0] mem_q [2];
    logic        head_q;
    logic        tail_q;
    logic [1:0]  count_q;
    logic [4:0]  last_rd_q;
    logic [15:0] dec_count_q;

    logic        push;
    logic        pop;
    logic [63:0] head_entry;
    logic [31:0] head_inst;
    logic [2:0]  alu_op_raw;
    logic        legal;

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign head_entry = mem_q[head_q];
    assign head_inst  = head_entry[31:0];

    // FIFO storage, pointers, occupancy, last legal rd and pop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            last_rd_q   <= 5'd0;
            dec_count_q <= 16'd0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= {bus.in_pc_4, bus.in_inst};
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q      <= ~head_q;
                dec_count_q <= dec_count_q + 16'd1;
                if (legal) begin
                    last_rd_q <= head_inst[15:11];
                end
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // R-type decode of the head instruction; anything unsupported is illegal
    always_comb begin
        alu_op_raw = 3'd7;
        legal      = 1'b0;
        if (head_inst[31:26] == 6'd0) begin
            case (head_inst[5:0])
                6'h20: begin alu_op_raw = 3'd0; legal = 1'b1; end
                6'h22: begin alu_op_raw = 3'd1; legal = 1'b1; end
                6'h24: begin alu_op_raw = 3'd2; legal = 1'b1; end
                6'h25: begin alu_op_raw = 3'd3; legal = 1'b1; end
                6'h2A: begin alu_op_raw = 3'd4; legal = 1'b1; end
                default: begin alu_op_raw = 3'd7; legal = 1'b0; end
            endcase
        end
    end

    // Output fields; qualified flags are forced inactive while empty
    always_comb begin
        bus.out_pc_4   = head_entry[63:32];
        bus.opcode     = head_inst[31:26];
        bus.rs         = head_inst[25:21];
        bus.rt         = head_inst[20:16];
        bus.rd         = head_inst[15:11];
        bus.shamt      = head_inst[10:6];
        bus.funct      = head_inst[5:0];
        bus.dec_count  = dec_count_q;
        bus.alu_op     = bus.out_valid ? alu_op_raw : 3'd7;
        bus.illegal    = bus.out_valid && !legal;
        bus.raw_hazard = bus.out_valid && (last_rd_q != 5'd0) &&
                         ((head_inst[25:21] == last_rd_q) || (head_inst[20:16] == last_rd_q));
    end

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode with a queue-based reference model.
module tb_inst_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    inst_decode_if bus ();

    inst_decode u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] q[$];
    logic [4:0]  m_last_rd;
    logic [15:0] m_cnt;

    function automatic logic [2:0] exp_alu(input logic [31:0] inst);
        if (inst[31:26] != 6'd0) return 3'd7;
        case (inst[5:0])
            6'h20:   return 3'd0;
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h2A:   return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic exp_hazard();
        logic [31:0] inst;
        if (q.size() == 0) return 1'b0;
        inst = q[0][31:0];
        return (m_last_rd != 5'd0) && (inst[25:21] == m_last_rd || inst[20:16] == m_last_rd);
    endfunction

    task automatic model_reset();
        q.delete();
        m_last_rd = 5'd0;
        m_cnt     = 16'd0;
    endtask

    // One clock: model evaluates handshakes from pre-edge inputs, then waits to negedge
    task automatic tick();
        bit          push, pop;
        logic [63:0] head;
        push = bus.in_valid && (q.size() < 2);
        pop  = bus.out_ready && (q.size() > 0);
        head = (q.size() > 0) ? q[0] : 64'd0;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 16'd1;
            if (exp_alu(head[31:0]) != 3'd7) m_last_rd = head[15:11];
        end
        if (push) q.push_back({bus.in_pc_4, bus.in_inst});
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.alu_op !== 3'd7 || bus.illegal !== 1'b0 || bus.raw_hazard !== 1'b0)
            begin errors++; $display("FAIL rst_flags got=%0d/%0b/%0b exp=7/0/0",
                bus.alu_op, bus.illegal, bus.raw_hazard); end
        checks++; if (bus.dec_count !== 16'd0 || bus.out_pc_4 !== 32'd0) begin errors++;
            $display("FAIL rst_count_data cnt=%0d pc=%0h exp=0/0", bus.dec_count, bus.out_pc_4); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // first push must land at the first edge after release
        bus.in_valid = 1'b1; bus.in_inst = 32'h0000_0020; bus.in_pc_4 = 32'd77;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc_4 !== 32'd77) begin errors++;
            $display("FAIL first_push got=%0b/%0d exp=1/77", bus.out_valid, bus.out_pc_4); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_inst = 32'h0022_1820; bus.in_pc_4 = 32'd1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.rs !== 5'd1 || bus.rt !== 5'd2 ||
            bus.rd !== 5'd3) begin errors++; $display("FAIL basic_fields v=%0b rs=%0d rt=%0d rd=%0d exp=1/1/2/3",
                bus.out_valid, bus.rs, bus.rt, bus.rd); end
        checks++; if (bus.alu_op !== 3'd0 || bus.illegal !== 1'b0 || bus.raw_hazard !== 1'b0 ||
            bus.out_pc_4 !== 32'd1) begin errors++; $display("FAIL basic_dec alu=%0d ill=%0b hz=%0b pc=%0d exp=0/0/0/1",
                bus.alu_op, bus.illegal, bus.raw_hazard, bus.out_pc_4); end
        tick();
        checks++; if (bus.dec_count !== m_cnt || bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL basic_pop cnt=%0d v=%0b exp=%0d/0", bus.dec_count, bus.out_valid, m_cnt); end
        bus.in_valid = 1'b1; bus.in_inst = 32'h0065_2020; bus.in_pc_4 = 32'd2;
        tick();
        checks++; if (bus.raw_hazard !== 1'b1 || bus.rd !== 5'd4) begin errors++;
            $display("FAIL hazard_set hz=%0b rd=%0d exp=1/4", bus.raw_hazard, bus.rd); end
        // push rs=rt=0 while popping add 4,3,5
        bus.in_inst = 32'h0000_0020; bus.in_pc_4 = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.raw_hazard !== 1'b0 || bus.out_pc_4 !== 32'd3) begin errors++;
            $display("FAIL hazard_zero hz=%0b pc=%0d exp=0/3", bus.raw_hazard, bus.out_pc_4); end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] insts [3];
        insts[0] = 32'h0022_3020; insts[1] = 32'h0022_3822; insts[2] = 32'h0022_4024;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_inst = insts[i]; bus.in_pc_4 = 32'd10 + i;
            tick();
            checks++; if (bus.in_ready !== (i == 0)) begin errors++;
                $display("FAIL full_ready push=%0d got=%0b exp=%0b", i, bus.in_ready, (i == 0)); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc_4 !== 32'd10 + i) begin errors++;
                $display("FAIL drain_order i=%0d v=%0b pc=%0d exp=1/%0d", i, bus.out_valid,
                    bus.out_pc_4, 10 + i); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0 || q.size() != 0) begin errors++;
            $display("FAIL drain_empty v=%0b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [15:0] c0;
        bus.in_valid = 1'b1; bus.in_inst = 32'h8C22_0000; bus.in_pc_4 = 32'd20;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.illegal !== 1'b1 || bus.alu_op !== 3'd7) begin errors++;
            $display("FAIL illegal_dec ill=%0b alu=%0d exp=1/7", bus.illegal, bus.alu_op); end
        c0 = bus.dec_count;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.dec_count !== c0 + 16'd1) begin errors++;
            $display("FAIL illegal_cnt got=%0d exp=%0d", bus.dec_count, c0 + 16'd1); end
        // last legal rd was 7 (sub in the full test); rs=7 must still flag
        bus.in_valid = 1'b1; bus.in_inst = {6'd0, 5'd7, 5'd0, 5'd9, 5'd0, 6'h20};
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.raw_hazard !== 1'b1) begin errors++;
            $display("FAIL illegal_keeps_rd hz=%0b exp=1", bus.raw_hazard); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = 32'h0043_2025; bus.in_pc_4 = 32'd100;
        tick();
        c0 = bus.dec_count;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_inst = 32'h0043_2025; bus.in_pc_4 = 32'd101 + i;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc_4 !== 32'd100 + i) begin errors++;
                $display("FAIL b2b i=%0d v=%0b pc=%0d exp=1/%0d", i, bus.out_valid,
                    bus.out_pc_4, 100 + i); end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.dec_count !== c0 + 16'd10) begin errors++;
            $display("FAIL b2b_cnt got=%0d exp=%0d", bus.dec_count, c0 + 16'd10); end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] fn [5];
        fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h2A;
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_pc_4   = $urandom;
            if ($urandom_range(0, 3) != 0)
                bus.in_inst = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                               fn[$urandom_range(0, 4)]};
            else
                bus.in_inst = $urandom;
            tick();
            checks++; if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2))
                begin errors++; $display("FAIL rnd_hs n=%0d v=%0b r=%0b size=%0d", n,
                    bus.out_valid, bus.in_ready, q.size()); end
            checks++; if (bus.dec_count !== m_cnt || bus.raw_hazard !== exp_hazard()) begin
                errors++; $display("FAIL rnd_cnt_hz n=%0d cnt=%0d hz=%0b exp=%0d/%0b", n,
                    bus.dec_count, bus.raw_hazard, m_cnt, exp_hazard()); end
            if (q.size() != 0) begin
                checks++; if (bus.out_pc_4 !== q[0][63:32] || bus.rd !== q[0][15:11] ||
                    bus.alu_op !== exp_alu(q[0][31:0]) ||
                    bus.illegal !== (exp_alu(q[0][31:0]) == 3'd7)) begin errors++;
                    $display("FAIL rnd_head n=%0d pc=%0h alu=%0d ill=%0b exp_pc=%0h exp_alu=%0d",
                        n, bus.out_pc_4, bus.alu_op, bus.illegal, q[0][63:32],
                        exp_alu(q[0][31:0])); end
            end else begin
                checks++; if (bus.alu_op !== 3'd7 || bus.illegal !== 1'b0) begin errors++;
                    $display("FAIL rnd_empty n=%0d alu=%0d ill=%0b exp=7/0", n, bus.alu_op,
                        bus.illegal); end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick(); tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int guard = 0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_inst = 32'h0000_0020; bus.in_pc_4 = 32'd5;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        checks++; if (bus.dec_count !== 16'hFFFF) begin errors++;
            $display("FAIL wrap_max got=%0h exp=ffff", bus.dec_count); end
        tick();
        checks++; if (bus.dec_count !== 16'h0000) begin errors++;
            $display("FAIL wrap_zero got=%0h exp=0", bus.dec_count); end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_inst = 32'h0022_1820; bus.in_pc_4 = 32'd50 + i;
            tick();
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_hs v=%0b r=%0b exp=0/1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.dec_count !== 16'd0 || bus.alu_op !== 3'd7) begin errors++;
            $display("FAIL midrst_cnt cnt=%0d alu=%0d exp=0/7", bus.dec_count, bus.alu_op); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.in_valid = 1'b1; bus.in_inst = 32'h0022_182A; bus.in_pc_4 = 32'd60;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_pc_4 !== 32'd60 || bus.alu_op !== 3'd4 || bus.raw_hazard !== 1'b0)
            begin errors++; $display("FAIL midrst_after pc=%0d alu=%0d hz=%0b exp=60/4/0",
                bus.out_pc_4, bus.alu_op, bus.raw_hazard); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_inst = 32'd0; bus.in_pc_4 = 32'd0;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_illegal();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
